btb_predictor: RTL and testbench

BTB_PREDICTOR -- requirements
Module: btb_predictor

---
 rtl/btb_predictor.sv | 84 ++++++++
 tb/tb_btb_predictor.sv | 123 ++++++++++++
 2 files changed

// File: rtl/btb_predictor.sv
// btb_predictor: direct-mapped branch target buffer with 2-bit counters and perf counters
module btb_predictor #(
  parameter int ADDR_W  = 32,
  parameter int ENTRIES = 16,
  parameter int CNT_W   = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] lookup_pc_i,
  output logic              hit_o,
  output logic              pred_taken_o,
  output logic [ADDR_W-1:0] pred_target_o,
  input  logic              upd_valid_i,
  input  logic [ADDR_W-1:0] upd_pc_i,
  input  logic [ADDR_W-1:0] upd_target_i,
  input  logic              upd_taken_i,
  input  logic              upd_is_jump_i,
  input  logic              upd_mispredict_i,
  input  logic              flush_i,
  output logic [CNT_W-1:0]  perf_mispredict_o,
  output logic [CNT_W-1:0]  perf_update_o
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = ADDR_W - IDX_W - 2;
  logic              valid  [ENTRIES];
  logic [1:0]        ctr    [ENTRIES];
  logic              jmp    [ENTRIES];
  logic [TAG_W-1:0]  tag    [ENTRIES];
  logic [ADDR_W-1:0] target [ENTRIES];
  logic [IDX_W-1:0]  l_idx, u_idx;
  logic [TAG_W-1:0]  l_tag, u_tag;
  logic              u_hit, upd, write;
  logic [1:0]        ctr_nx, u_ctr;
  logic [CNT_W-1:0]  upd_cnt, mis_cnt;
  assign l_idx = lookup_pc_i[IDX_W+1:2];
  assign l_tag = lookup_pc_i[ADDR_W-1:IDX_W+2];
  assign u_idx = upd_pc_i[IDX_W+1:2];
  assign u_tag = upd_pc_i[ADDR_W-1:IDX_W+2];
  // Lookup reads only through valid, so unreset tag/target never reach the outputs.
  assign hit_o         = valid[l_idx] && (tag[l_idx] == l_tag);
  assign pred_taken_o  = hit_o && (ctr[l_idx][1] || jmp[l_idx]);
  assign pred_target_o = pred_taken_o ? target[l_idx] : '0;
  assign u_hit = valid[u_idx] && (tag[u_idx] == u_tag);
  assign u_ctr = ctr[u_idx];
  assign upd   = upd_valid_i && !flush_i;
  assign write = upd && (u_hit || upd_taken_i);
  // Counter update: fresh allocations start strong for jumps, weak-taken otherwise.
  always_comb
    ctr_nx = !u_hit ? (upd_is_jump_i ? 2'b11 : 2'b10)
           : upd_taken_i ? ((u_ctr == 2'b11) ? 2'b11 : u_ctr + 2'd1)
           : ((u_ctr == 2'b00) ? 2'b00 : u_ctr - 2'd1);
  // Entry state that must be reset: valid, counter, jump; flush wins over update.
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid[i] <= 1'b0;
        ctr[i]   <= 2'b00;
        jmp[i]   <= 1'b0;
      end
    end else if (flush_i) begin
      for (int i = 0; i < ENTRIES; i++) valid[i] <= 1'b0;
    end else if (write) begin
      valid[u_idx] <= 1'b1;
      ctr[u_idx]   <= ctr_nx;
      jmp[u_idx]   <= upd_is_jump_i;
    end
  // Tag and target are only rewritten by taken updates (hit keeps the same tag).
  always_ff @(posedge clk_i)
    if (upd && upd_taken_i) begin
      tag[u_idx]    <= u_tag;
      target[u_idx] <= upd_target_i;
    end
  // Saturating performance counters, independent of flush.
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      upd_cnt <= '0;
      mis_cnt <= '0;
    end else if (upd_valid_i) begin
      if (!(&upd_cnt)) upd_cnt <= upd_cnt + CNT_W'(1);
      if (upd_mispredict_i && !(&mis_cnt)) mis_cnt <= mis_cnt + CNT_W'(1);
    end
  assign perf_update_o     = upd_cnt;
  assign perf_mispredict_o = mis_cnt;
endmodule

// File: tb/tb_btb_predictor.sv
// tb_btb_predictor: table-driven directed test of btb_predictor
module tb_btb_predictor;
  localparam int CW = 5;
  logic          clk = 0, rst_i = 0;
  logic [31:0]   lookup_pc_i = 0, upd_pc_i = 0, upd_target_i = 0, pred_target_o;
  logic          upd_valid_i = 0, upd_taken_i = 0, upd_is_jump_i = 0, upd_mispredict_i = 0, flush_i = 0;
  logic          hit_o, pred_taken_o;
  logic [CW-1:0] perf_mispredict_o, perf_update_o;
  int            total = 0, bad = 0;

  btb_predictor #(.ADDR_W(32), .ENTRIES(16), .CNT_W(CW)) dut (
    .clk_i(clk), .rst_i(rst_i), .lookup_pc_i(lookup_pc_i), .hit_o(hit_o),
    .pred_taken_o(pred_taken_o), .pred_target_o(pred_target_o),
    .upd_valid_i(upd_valid_i), .upd_pc_i(upd_pc_i), .upd_target_i(upd_target_i),
    .upd_taken_i(upd_taken_i), .upd_is_jump_i(upd_is_jump_i),
    .upd_mispredict_i(upd_mispredict_i), .flush_i(flush_i),
    .perf_mispredict_o(perf_mispredict_o), .perf_update_o(perf_update_o));

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] lpc;
    logic        uv;
    logic [31:0] upc, utgt;
    logic        ut, uj, um, fl, eh, et;
    logic [31:0] etgt;
    int          pu, pm;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic [31:0] lpc, logic uv, logic [31:0] upc, logic [31:0] utgt,
                              logic ut, logic uj, logic um, logic fl, logic eh, logic et,
                              logic [31:0] etgt, int pu, int pm);
    vec_t v;
    v.lpc = lpc; v.uv = uv; v.upc = upc; v.utgt = utgt; v.ut = ut; v.uj = uj; v.um = um;
    v.fl = fl; v.eh = eh; v.et = et; v.etgt = etgt; v.pu = pu; v.pm = pm;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s step %0d: got %h want %h", name, idx, act, exp);
    end
  endtask

  task automatic chk_all(input int idx, input logic eh, input logic et, input logic [31:0] etgt,
                         input int pu, input int pm);
    chk("hit", idx, 32'(hit_o), 32'(eh));
    chk("taken", idx, 32'(pred_taken_o), 32'(et));
    chk("target", idx, pred_target_o, etgt);
    chk("perf_update", idx, 32'(perf_update_o), pu);
    chk("perf_mispredict", idx, 32'(perf_mispredict_o), pm);
  endtask

  initial begin
    // Expected outputs are the pre-edge values seen while the row's inputs are applied.
    //              lpc    uv upc    utgt   ut uj um fl  eh et etgt   pu  pm
    vecs.push_back(mk(32'h40, 0, 32'h0,  32'h0,   0, 0, 0, 0, 0, 0, 32'h0,   0, 0));
    vecs.push_back(mk(32'h40, 1, 32'h40, 32'h80,  1, 0, 0, 0, 0, 0, 32'h0,   0, 0));
    vecs.push_back(mk(32'h40, 1, 32'h40, 32'h0,   0, 0, 1, 0, 1, 1, 32'h80,  1, 0));
    vecs.push_back(mk(32'h40, 1, 32'h40, 32'h0,   0, 0, 0, 0, 1, 0, 32'h0,   2, 1));
    vecs.push_back(mk(32'h40, 1, 32'h40, 32'h80,  1, 0, 0, 0, 1, 0, 32'h0,   3, 1));
    vecs.push_back(mk(32'h40, 1, 32'h40, 32'h80,  1, 0, 0, 0, 1, 0, 32'h0,   4, 1));
    vecs.push_back(mk(32'h40, 1, 32'h40, 32'h80,  1, 0, 0, 0, 1, 1, 32'h80,  5, 1));
    vecs.push_back(mk(32'h40, 1, 32'h40, 32'h80,  1, 0, 0, 0, 1, 1, 32'h80,  6, 1));
    vecs.push_back(mk(32'h40, 1, 32'h40, 32'h90,  1, 0, 0, 0, 1, 1, 32'h80,  7, 1));
    vecs.push_back(mk(32'h40, 1, 32'h40, 32'hF00, 0, 0, 0, 0, 1, 1, 32'h90,  8, 1));
    vecs.push_back(mk(32'h40, 0, 32'h0,  32'h0,   0, 0, 0, 0, 1, 1, 32'h90,  9, 1));
    vecs.push_back(mk(32'h44, 1, 32'h44, 32'h100, 1, 0, 0, 0, 0, 0, 32'h0,   9, 1));
    vecs.push_back(mk(32'h84, 1, 32'h84, 32'h10,  1, 0, 0, 0, 0, 0, 32'h0,  10, 1));
    vecs.push_back(mk(32'h44, 0, 32'h0,  32'h0,   0, 0, 0, 0, 0, 0, 32'h0,  11, 1));
    vecs.push_back(mk(32'h84, 0, 32'h0,  32'h0,   0, 0, 0, 0, 1, 1, 32'h10, 11, 1));
    vecs.push_back(mk(32'h48, 1, 32'h48, 32'h200, 1, 1, 0, 0, 0, 0, 32'h0,  11, 1));
    vecs.push_back(mk(32'h48, 1, 32'h48, 32'h0,   0, 0, 0, 0, 1, 1, 32'h200,12, 1));
    vecs.push_back(mk(32'h48, 1, 32'h48, 32'h0,   0, 0, 0, 0, 1, 1, 32'h200,13, 1));
    vecs.push_back(mk(32'h48, 0, 32'h0,  32'h0,   0, 0, 0, 0, 1, 0, 32'h0,  14, 1));
    vecs.push_back(mk(32'h0C, 1, 32'h0C, 32'h300, 0, 0, 0, 0, 0, 0, 32'h0,  14, 1));
    vecs.push_back(mk(32'h0C, 0, 32'h0,  32'h0,   0, 0, 0, 0, 0, 0, 32'h0,  15, 1));
    vecs.push_back(mk(32'h43, 0, 32'h0,  32'h0,   0, 0, 0, 0, 1, 1, 32'h90, 15, 1));
    vecs.push_back(mk(32'h84, 1, 32'h4C, 32'h400, 1, 0, 1, 1, 1, 1, 32'h10, 15, 1));
    vecs.push_back(mk(32'h84, 0, 32'h0,  32'h0,   0, 0, 1, 1, 0, 0, 32'h0,  16, 2));
    vecs.push_back(mk(32'h4C, 0, 32'h0,  32'h0,   0, 0, 0, 0, 0, 0, 32'h0,  16, 2));
    vecs.push_back(mk(32'h40, 0, 32'h0,  32'h0,   0, 0, 0, 0, 0, 0, 32'h0,  16, 2));

    repeat (2) @(posedge clk);
    @(negedge clk) rst_i = 1;
    foreach (vecs[i]) begin
      @(negedge clk);
      lookup_pc_i = vecs[i].lpc; upd_valid_i = vecs[i].uv; upd_pc_i = vecs[i].upc;
      upd_target_i = vecs[i].utgt; upd_taken_i = vecs[i].ut; upd_is_jump_i = vecs[i].uj;
      upd_mispredict_i = vecs[i].um; flush_i = vecs[i].fl;
      #1 chk_all(i, vecs[i].eh, vecs[i].et, vecs[i].etgt, vecs[i].pu, vecs[i].pm);
    end

    // Asynchronous reset in the middle of a cycle.
    @(negedge clk);
    lookup_pc_i = 32'h40; upd_valid_i = 1; upd_pc_i = 32'h40; upd_target_i = 32'h80;
    upd_taken_i = 1; upd_is_jump_i = 0; upd_mispredict_i = 1; flush_i = 0;
    @(negedge clk);
    upd_valid_i = 0;
    #1 chk_all(100, 1, 1, 32'h80, 17, 3);
    #1 rst_i = 0;
    #1 chk_all(101, 0, 0, 32'h0, 0, 0);
    upd_valid_i = 1;
    @(negedge clk);
    #1 chk_all(102, 0, 0, 32'h0, 0, 0);
    rst_i = 1; upd_valid_i = 0;
    @(negedge clk);
    #1 chk_all(103, 0, 0, 32'h0, 0, 0);

    // Perf counters saturate at all-ones.
    upd_valid_i = 1; upd_taken_i = 0; upd_mispredict_i = 1;
    repeat (40) @(negedge clk);
    upd_valid_i = 0;
    #1 chk_all(104, 0, 0, 32'h0, 31, 31);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
